// File: rtl/xosera_bus_sync.sv
// xosera_bus_sync: host-bus front end for the Xosera register file.
// Synchronises the asynchronous 68k-style bus into the pixel clock, filters
// chip-select glitches, emits one strobe per bus cycle, assembles byte writes
// into 16-bit words and serves read words back out a byte at a time.
// Optional feature macro: BUS_ORDER_CHECK_EN (sticky even/odd write ordering error).
//
// state   | meaning
// IDLE    | waiting for cs_n to be seen low for FILTER_CYCLES synced cycles
// ACTIVE  | single cycle: issue the write or read strobe
// RELEASE | waiting for cs_n to be seen high for FILTER_CYCLES synced cycles
module xosera_bus_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        bus_cs_n_i,
    input  logic        bus_rd_nwr_i,
    input  logic        bus_bytesel_i,
    input  logic [3:0]  bus_reg_num_i,
    input  logic [7:0]  bus_data_i,
    output logic        wr_strobe_o,
    output logic        rd_strobe_o,
    output logic [3:0]  reg_num_o,
    output logic        bytesel_o,
    output logic [7:0]  data_o,
    output logic [15:0] word_o,
    input  logic [15:0] rd_data_i,
    output logic [7:0]  bus_data_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;

    // Packed bus bundle: {cs_n, rd_nwr, bytesel, reg_num[3:0], data[7:0]}
    localparam int              W          = 15;
    localparam logic [W-1:0]    SYNC_RST   = 15'h4000;
    localparam logic [2:0]      FILTER_CNT = 3'(FILTER_CYCLES);
    localparam logic [1:0]      FLUSH_INIT = 2'(SYNC_STAGES);

    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] sync_d [SYNC_STAGES];
    logic [W-1:0] bus_s;
    logic         s_cs_n;

    state_t       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d, cnt_inc;
    logic [1:0]   flush_q, flush_d;
    logic         capture;

    logic         wr_strobe_q, wr_strobe_d;
    logic         rd_strobe_q, rd_strobe_d;
    logic [3:0]   reg_num_q, reg_num_d;
    logic         bytesel_q, bytesel_d;
    logic [7:0]   data_q, data_d;
    logic         rd_nwr_q, rd_nwr_d;
    logic [7:0]   even_latch_q, even_latch_d;
    logic [7:0]   read_latch_q, read_latch_d;
    logic [7:0]   bus_data_q, bus_data_d;

    // Synchroniser chain: shift the raw bundle one stage per clock
    always_comb begin
        sync_d[0] = {bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i, bus_data_i};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign bus_s  = sync_q[SYNC_STAGES-1];
    assign s_cs_n = bus_s[14];

    // Synchroniser registers; cs_n resets high so the bus looks released
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
        end
    end

    // The reset value of the chain is not a real observation of cs_n, so the
    // release filter ignores the first SYNC_STAGES cycles after reset.
    assign flush_d = (flush_q != 2'd0) ? flush_q - 2'd1 : flush_q;
    assign cnt_inc = cnt_q + 3'd1;

    // FSM next state and level filter counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_cs_n) begin
                    cnt_d = 3'd0;
                end else if (cnt_inc == FILTER_CNT) begin
                    cnt_d   = 3'd0;
                    state_d = ACTIVE;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ACTIVE: begin
                cnt_d   = 3'd0;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!s_cs_n || flush_q != 2'd0) begin
                    cnt_d = 3'd0;
                end else if (cnt_inc == FILTER_CNT) begin
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                cnt_d   = 3'd0;
                state_d = RELEASE;
            end
        endcase
    end

    // Capture, strobes, byte assembly and read byte steering
    always_comb begin
        reg_num_d    = reg_num_q;
        bytesel_d    = bytesel_q;
        data_d       = data_q;
        rd_nwr_d     = rd_nwr_q;
        even_latch_d = even_latch_q;
        read_latch_d = read_latch_q;
        bus_data_d   = bus_data_q;
        wr_strobe_d  = (state_q == ACTIVE) && !rd_nwr_q;
        rd_strobe_d  = (state_q == ACTIVE) && rd_nwr_q;
        if (capture) begin
            rd_nwr_d  = bus_s[13];
            bytesel_d = bus_s[12];
            reg_num_d = bus_s[11:8];
            data_d    = bus_s[7:0];
        end
        if (wr_strobe_q && !bytesel_q) begin
            even_latch_d = data_q;
        end
        if (rd_strobe_q) begin
            if (!bytesel_q) begin
                read_latch_d = rd_data_i[7:0];
                bus_data_d   = rd_data_i[15:8];
            end else begin
                bus_data_d   = read_latch_q;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= RELEASE;
            cnt_q        <= 3'd0;
            flush_q      <= FLUSH_INIT;
            wr_strobe_q  <= 1'b0;
            rd_strobe_q  <= 1'b0;
            reg_num_q    <= 4'd0;
            bytesel_q    <= 1'b0;
            data_q       <= 8'd0;
            rd_nwr_q     <= 1'b0;
            even_latch_q <= 8'd0;
            read_latch_q <= 8'd0;
            bus_data_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_q      <= flush_d;
            wr_strobe_q  <= wr_strobe_d;
            rd_strobe_q  <= rd_strobe_d;
            reg_num_q    <= reg_num_d;
            bytesel_q    <= bytesel_d;
            data_q       <= data_d;
            rd_nwr_q     <= rd_nwr_d;
            even_latch_q <= even_latch_d;
            read_latch_q <= read_latch_d;
            bus_data_q   <= bus_data_d;
        end
    end

    assign wr_strobe_o = wr_strobe_q;
    assign rd_strobe_o = rd_strobe_q;
    assign reg_num_o   = reg_num_q;
    assign bytesel_o   = bytesel_q;
    assign data_o      = data_q;
    assign word_o      = {even_latch_q, data_q};
    assign bus_data_o  = bus_data_q;

`ifdef BUS_ORDER_CHECK_EN
    logic       pend_even_q, pend_even_d;
    logic [3:0] even_reg_q, even_reg_d;
    logic       err_q, err_d;

    // Track the pending even write; flag odd writes that don't pair with it
    always_comb begin
        pend_even_d = pend_even_q;
        even_reg_d  = even_reg_q;
        err_d       = err_q;
        if (wr_strobe_q) begin
            if (!bytesel_q) begin
                pend_even_d = 1'b1;
                even_reg_d  = reg_num_q;
            end else begin
                if (!pend_even_q || (reg_num_q != even_reg_q)) err_d = 1'b1;
                pend_even_d = 1'b0;
            end
        end
    end

    // Ordering tracker registers; error is sticky until reset
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pend_even_q <= 1'b0;
            even_reg_q  <= 4'd0;
            err_q       <= 1'b0;
        end else begin
            pend_even_q <= pend_even_d;
            even_reg_q  <= even_reg_d;
            err_q       <= err_d;
        end
    end

    assign bus_err_o = err_q;
`else
    assign bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_xosera_bus_sync.sv
// Directed self-checking bench for xosera_bus_sync at default parameters.
module tb_xosera_bus_sync;

    logic        clk;
    logic        reset_n_i;
    logic        bus_cs_n_i;
    logic        bus_rd_nwr_i;
    logic        bus_bytesel_i;
    logic [3:0]  bus_reg_num_i;
    logic [7:0]  bus_data_i;
    logic        wr_strobe_o;
    logic        rd_strobe_o;
    logic [3:0]  reg_num_o;
    logic        bytesel_o;
    logic [7:0]  data_o;
    logic [15:0] word_o;
    logic [15:0] rd_data_i;
    logic [7:0]  bus_data_o;
    logic        bus_err_o;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    xosera_bus_sync dut (
        .clk           (clk),
        .reset_n_i     (reset_n_i),
        .bus_cs_n_i    (bus_cs_n_i),
        .bus_rd_nwr_i  (bus_rd_nwr_i),
        .bus_bytesel_i (bus_bytesel_i),
        .bus_reg_num_i (bus_reg_num_i),
        .bus_data_i    (bus_data_i),
        .wr_strobe_o   (wr_strobe_o),
        .rd_strobe_o   (rd_strobe_o),
        .reg_num_o     (reg_num_o),
        .bytesel_o     (bytesel_o),
        .data_o        (data_o),
        .word_o        (word_o),
        .rd_data_i     (rd_data_i),
        .bus_data_o    (bus_data_o),
        .bus_err_o     (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe_o) wr_cnt++;
        if (rd_strobe_o) rd_cnt++;
    end

    task automatic do_reset();
        @(posedge clk);
        #1 reset_n_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n_i = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    // One full bus cycle: cs_n falls, wait for a strobe (bounded), release.
    // lat is the number of clock edges from cs_n fall to strobe, 0 on timeout.
    task automatic access(input logic rd, input logic bsel, input logic [3:0] rn,
                          input logic [7:0] dat, input logic [15:0] rdat,
                          output int lat, output logic wr_seen, output logic rd_seen,
                          output logic [3:0] reg_seen, output logic [15:0] word_seen);
        lat = 0; wr_seen = 1'b0; rd_seen = 1'b0; reg_seen = 4'h0; word_seen = 16'h0;
        @(posedge clk);
        #1;
        bus_rd_nwr_i = rd; bus_bytesel_i = bsel; bus_reg_num_i = rn;
        bus_data_i = dat; rd_data_i = rdat; bus_cs_n_i = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (wr_strobe_o || rd_strobe_o) begin
                lat = i; wr_seen = wr_strobe_o; rd_seen = rd_strobe_o;
                reg_seen = reg_num_o; word_seen = word_o;
                break;
            end
        end
        @(posedge clk);
        #1 bus_cs_n_i = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_reset();
        #1 reset_n_i = 1'b0;
        bus_cs_n_i = 1'b1; bus_rd_nwr_i = 1'b0; bus_bytesel_i = 1'b0;
        bus_reg_num_i = 4'h0; bus_data_i = 8'h00; rd_data_i = 16'h0000;
        repeat (2) @(negedge clk);
        checks++;
        if ({wr_strobe_o, rd_strobe_o, reg_num_o, bytesel_o, data_o, word_o, bus_data_o, bus_err_o} !== '0) begin
            errors++;
            $display("FAIL reset_in: outputs got wr=%b rd=%b reg=%h data=%h word=%h bd=%h err=%b, required all 0",
                     wr_strobe_o, rd_strobe_o, reg_num_o, data_o, word_o, bus_data_o, bus_err_o);
        end
        @(posedge clk);
        #1 reset_n_i = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++;
        if (word_o !== 16'h0000 || bus_data_o !== 8'h00 || wr_cnt + rd_cnt != 0) begin
            errors++;
            $display("FAIL reset_after: word=%h bd=%h strobes=%0d, required 0000 00 0",
                     word_o, bus_data_o, wr_cnt + rd_cnt);
        end
    endtask

    task automatic test_write_pair();
        int lat; logic ws, rs; logic [3:0] rn; logic [15:0] wd;
        access(1'b0, 1'b0, 4'h3, 8'hAB, 16'h0000, lat, ws, rs, rn, wd);
        checks++;
        if (lat != 5) begin errors++; $display("FAIL even_wr_latency: got %0d required 5", lat); end
        checks++;
        if (ws !== 1'b1 || rs !== 1'b0) begin errors++; $display("FAIL even_wr_strobe: wr=%b rd=%b required 1 0", ws, rs); end
        access(1'b0, 1'b1, 4'h3, 8'hCD, 16'h0000, lat, ws, rs, rn, wd);
        checks++;
        if (lat != 5) begin errors++; $display("FAIL odd_wr_latency: got %0d required 5", lat); end
        checks++;
        if (ws !== 1'b1 || rn !== 4'h3) begin errors++; $display("FAIL odd_wr_reg: wr=%b reg=%h required 1 3", ws, rn); end
        checks++;
        if (wd !== 16'hABCD) begin errors++; $display("FAIL odd_wr_word: got %h required abcd", wd); end
        checks++;
        if (wr_cnt != 2 || rd_cnt != 0) begin errors++; $display("FAIL wr_count: wr=%0d rd=%0d required 2 0", wr_cnt, rd_cnt); end
        checks++;
        if (bus_err_o !== 1'b0) begin errors++; $display("FAIL pair_err: got %b required 0", bus_err_o); end
    endtask

    task automatic test_glitch();
        int base;
        base = wr_cnt + rd_cnt;
        @(posedge clk);
        #1 bus_reg_num_i = 4'h9; bus_data_i = 8'h77; bus_cs_n_i = 1'b0;
        @(posedge clk);
        #1 bus_cs_n_i = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (wr_cnt + rd_cnt != base) begin errors++; $display("FAIL glitch_strobe: got %0d strobes required 0", wr_cnt + rd_cnt - base); end
        checks++;
        if (reg_num_o !== 4'h3 || data_o !== 8'hCD) begin
            errors++; $display("FAIL glitch_capture: reg=%h data=%h required 3 cd", reg_num_o, data_o);
        end
    endtask

    task automatic test_read_pair();
        int lat; logic ws, rs; logic [3:0] rn; logic [15:0] wd;
        access(1'b1, 1'b0, 4'h5, 8'h00, 16'h1234, lat, ws, rs, rn, wd);
        checks++;
        if (lat != 5 || rs !== 1'b1 || ws !== 1'b0) begin
            errors++; $display("FAIL even_rd_strobe: lat=%0d rd=%b wr=%b required 5 1 0", lat, rs, ws);
        end
        checks++;
        if (bus_data_o !== 8'h12) begin errors++; $display("FAIL even_rd_byte: got %h required 12", bus_data_o); end
        access(1'b1, 1'b1, 4'h5, 8'h00, 16'hFFFF, lat, ws, rs, rn, wd);
        checks++;
        if (lat != 5 || rs !== 1'b1 || rn !== 4'h5) begin
            errors++; $display("FAIL odd_rd_strobe: lat=%0d rd=%b reg=%h required 5 1 5", lat, rs, rn);
        end
        checks++;
        if (bus_data_o !== 8'h34) begin errors++; $display("FAIL odd_rd_byte: got %h required 34", bus_data_o); end
        checks++;
        if (rd_cnt != 2) begin errors++; $display("FAIL rd_count: got %0d required 2", rd_cnt); end
    endtask

    task automatic test_back_to_back();
        int base;
        for (int gap = 2; gap >= 1; gap--) begin
            base = rd_cnt;
            @(posedge clk);
            #1 bus_rd_nwr_i = 1'b1; bus_bytesel_i = 1'b0; bus_reg_num_i = 4'h7;
            rd_data_i = 16'hBEEF; bus_cs_n_i = 1'b0;
            repeat (6) @(posedge clk);
            #1 bus_cs_n_i = 1'b1;
            repeat (gap) @(posedge clk);
            #1 bus_cs_n_i = 1'b0;
            repeat (12) @(posedge clk);
            #1 bus_cs_n_i = 1'b1;
            repeat (6) @(posedge clk);
            checks++;
            if (gap == 2 && rd_cnt - base != 2) begin
                errors++; $display("FAIL b2b_gap2: got %0d strobes required 2", rd_cnt - base);
            end else if (gap == 1 && rd_cnt - base != 1) begin
                errors++; $display("FAIL b2b_gap1: got %0d strobes required 1", rd_cnt - base);
            end
        end
    endtask

    task automatic test_reset_cs_low();
        int base;
        @(posedge clk);
        #1 bus_rd_nwr_i = 1'b1; bus_bytesel_i = 1'b1; bus_reg_num_i = 4'h6;
        rd_data_i = 16'hFFFF; bus_cs_n_i = 1'b0; reset_n_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n_i = 1'b1;
        base = wr_cnt + rd_cnt;
        repeat (10) @(posedge clk);
        checks++;
        if (wr_cnt + rd_cnt != base) begin errors++; $display("FAIL rst_low_nostrobe: got %0d strobes required 0", wr_cnt + rd_cnt - base); end
        #1 bus_cs_n_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus_cs_n_i = 1'b0;
        repeat (12) @(posedge clk);
        #1 bus_cs_n_i = 1'b1;
        repeat (6) @(posedge clk);
        checks++;
        if (rd_cnt + wr_cnt - base != 1) begin errors++; $display("FAIL rst_low_one_strobe: got %0d strobes required 1", rd_cnt + wr_cnt - base); end
        checks++;
        if (reg_num_o !== 4'h6 || bus_data_o !== 8'h00) begin
            errors++; $display("FAIL rst_low_capture: reg=%h bd=%h required 6 00", reg_num_o, bus_data_o);
        end
    endtask

    task automatic test_order_check();
        int lat; logic ws, rs; logic [3:0] rn; logic [15:0] wd;
        logic exp_err;
`ifdef BUS_ORDER_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        access(1'b0, 1'b0, 4'h1, 8'h11, 16'h0000, lat, ws, rs, rn, wd);
        access(1'b0, 1'b1, 4'h2, 8'h22, 16'h0000, lat, ws, rs, rn, wd);
        checks++;
        if (bus_err_o !== exp_err) begin errors++; $display("FAIL order_err_set: got %b required %b", bus_err_o, exp_err); end
        access(1'b0, 1'b0, 4'h4, 8'h44, 16'h0000, lat, ws, rs, rn, wd);
        access(1'b0, 1'b1, 4'h4, 8'h55, 16'h0000, lat, ws, rs, rn, wd);
        checks++;
        if (bus_err_o !== exp_err) begin errors++; $display("FAIL order_err_sticky: got %b required %b", bus_err_o, exp_err); end
        checks++;
        if (wd !== 16'h4455) begin errors++; $display("FAIL order_word: got %h required 4455", wd); end
        do_reset();
        checks++;
        if (bus_err_o !== 1'b0) begin errors++; $display("FAIL order_err_reset: got %b required 0", bus_err_o); end
    endtask

    initial begin
        test_reset();
        test_write_pair();
        test_glitch();
        test_read_pair();
        test_back_to_back();
        test_reset_cs_low();
        test_order_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xosera_bus_sync.md
Name: xosera_bus_sync

Overview:
- Host-bus front end that sits between the UPduino pin-level bus signals and the Xosera register file.
- Synchronises the asynchronous 68k-style bus (cs_n, rd_nwr, bytesel, reg_num, data) into the pixel-clock domain.
- Filters glitches and emits exactly one strobe per bus cycle.
- Assembles even/odd byte writes into 16-bit words and serves 16-bit read data back out as bytes.

Parameters:
- SYNC_STAGES, 2, synchroniser flop depth on every bus input (legal: 2 or 3).
- FILTER_CYCLES, 2, consecutive synced cycles cs_n must hold a level to count as asserted or released (legal: 1..4).

Ports:
- clk  in  1  pixel clock
- reset_n_i  in  1  reset, asynchronous assert, active-low
- bus_cs_n_i  in  1  raw chip select, active-low
- bus_rd_nwr_i  in  1  raw read(1)/write(0)
- bus_bytesel_i  in  1  raw byte select; 0 = even (high byte), 1 = odd (low byte)
- bus_reg_num_i  in  4  raw register number
- bus_data_i  in  8  raw write data
- wr_strobe_o  out  1  one-cycle pulse per write cycle
- rd_strobe_o  out  1  one-cycle pulse per read cycle
- reg_num_o  out  4  register number captured for the current cycle
- bytesel_o  out  1  byte select captured for the current cycle
- data_o  out  8  write byte captured for the current cycle
- word_o  out  16  {even_latch, data_o}; meaningful on odd writes
- rd_data_i  in  16  register read data; must be valid one cycle after rd_strobe_o
- bus_data_o  out  8  registered read byte toward the pin tri-state
- bus_err_o  out  1  sticky ordering error (optional feature only)

Behaviour:
- Synchronisation: every raw input passes through a SYNC_STAGES flop chain. All outputs are registered.
- Reset (reset_n_i low, asynchronous):
  - All outputs go to 0.
  - Synchroniser chains are set to 1 for cs_n and 0 for all other inputs.
  - even_latch and read_latch are cleared to 0.
  - FSM enters RELEASE, not IDLE.
- FSM states IDLE, ACTIVE, RELEASE; filter counter is 3 bits.
- IDLE:
  - Counter increments while synced cs_n = 0 and clears when synced cs_n = 1.
  - When the counter reaches FILTER_CYCLES, go to ACTIVE.
  - In that same edge, capture reg_num/bytesel/data/rd_nwr from the synced copies into the output registers.
- ACTIVE: lasts exactly one cycle.
  - Pulses wr_strobe_o if the captured rd_nwr = 0, else rd_strobe_o.
  - Next state is RELEASE; counter cleared.
- RELEASE:
  - Counter counts synced cs_n = 1 cycles and clears on 0.
  - At FILTER_CYCLES, go to IDLE.
  - No strobes are generated in this state.
- Latency: raw cs_n fall to strobe high is SYNC_STAGES + FILTER_CYCLES + 1 clocks, i.e. 5 at defaults.
- Glitch rejection: a cs_n low pulse shorter than FILTER_CYCLES synced cycles produces no strobe and leaves no captured-state change.
- Reset while cs_n is held low: no strobe until cs_n has been seen high for FILTER_CYCLES cycles, then low again.
- Writes:
  - Even write (bytesel = 0): the cycle after wr_strobe_o, even_latch <= data_o.
  - Odd write: word_o = {even_latch, data_o}, valid in the wr_strobe_o cycle.
  - even_latch persists across cycles and registers. An odd write without a preceding even write uses the stale latch value.
- Reads:
  - Even read: read_latch <= rd_data_i one cycle after rd_strobe_o; bus_data_o <= rd_data_i[15:8] in the same edge.
  - Odd read: bus_data_o <= read_latch[7:0] one cycle after rd_strobe_o. rd_strobe_o is still pulsed, and rd_data_i is ignored.
  - bus_data_o otherwise holds its last value.
- Data settle: the bus host presents data/reg_num before cs_n falls. Data changing after the capture edge is ignored.

Optional Feature:
- Macro: BUS_ORDER_CHECK_EN.
- Defined:
  - Tracks a "pending even" flag and the reg_num of the last even write.
  - bus_err_o is set and held (until reset) on either of:
    - an odd write whose reg_num differs from the pending even write;
    - an odd write with no pending even write.
  - The flag clears on every odd write.
- Undefined: bus_err_o is tied to 0 and no tracking logic is built.

Test Plan:
- Reset, then even write reg 3 data 0xAB followed by odd write reg 3 data 0xCD:
  - wr_strobe_o pulses twice, each 5 clocks after the respective cs_n fall.
  - Second pulse shows reg_num_o = 3, word_o = 0xABCD.
- cs_n low for 1 clock only -> no wr/rd strobe; reg_num_o unchanged.
- Hold cs_n low through reset release:
  - No strobe while cs_n stays low.
  - Raise cs_n for 2 clocks, lower it again -> exactly one strobe.
- Even read reg 5 with rd_data_i = 0x1234, then odd read reg 5 with rd_data_i = 0xFFFF:
  - bus_data_o = 0x12, then 0x34.
  - rd_strobe_o pulses twice.
- Back-to-back cycles with cs_n high for exactly FILTER_CYCLES (2) synced clocks between them -> two strobes, no merge; with 1 clock high -> one strobe.
- BUS_ORDER_CHECK_EN: even write reg 1 followed by odd write reg 2 -> bus_err_o = 1, stays 1 through later correct pairs until reset.
